// File: rtl/imem_loader.sv
// Instruction memory loader: assembles a length-prefixed, XOR-checksummed little-endian
// byte stream into 32-bit words and writes them to consecutive instruction memory addresses.
module imem_loader #(
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned MAX_WORDS = 65536,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              wr_en,
   output logic [31:0]       wr_addr,
   output logic [31:0]       wr_data,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   words_loaded
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_DATA,
      S_CSUM,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [ADDR_W:0] WL_ONE = (ADDR_W + 1)'(1);

   state_t          state_q, state_d;
   logic [1:0]      bcnt_q, bcnt_d;
   logic [23:0]     asm_q, asm_d;
   logic [31:0]     csum_q, csum_d;
   logic [ADDR_W:0] len_q, len_d;
   logic [ADDR_W:0] wl_q, wl_d;
   logic            wr_en_q, wr_en_d;
   logic [31:0]     wr_addr_q, wr_addr_d;
   logic [31:0]     wr_data_q, wr_data_d;
   logic            hold_q, hold_d;
   logic            done_q, done_d;
   logic            err_q, err_d;

   logic            active;
   logic            xfer;
   logic            word_done;
   logic [31:0]     word;

   assign active    = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
   assign xfer      = active && in_valid;
   assign word_done = xfer && (bcnt_q == 2'd3);
   // The completing byte is used directly, so the word is available on its own transfer edge.
   assign word      = {in_data, asm_q};

   always_comb begin
      state_d   = state_q;
      bcnt_d    = bcnt_q;
      asm_d     = asm_q;
      csum_d    = csum_q;
      len_d     = len_q;
      wl_d      = wl_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      hold_d    = hold_q;
      done_d    = done_q;
      err_d     = err_q;

      if (xfer) begin
         bcnt_d = bcnt_q + 2'd1;
         case (bcnt_q)
            2'd0:    asm_d[7:0]   = in_data;
            2'd1:    asm_d[15:8]  = in_data;
            2'd2:    asm_d[23:16] = in_data;
            default: asm_d        = asm_q;
         endcase
      end

      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_d = S_LEN;
               bcnt_d  = 2'd0;
               csum_d  = '0;
               wl_d    = '0;
               done_d  = 1'b0;
               err_d   = 1'b0;
               hold_d  = 1'b1;
            end
         end
         S_LEN: begin
            if (word_done) begin
               if (word == 32'd0) begin
                  state_d = S_CSUM;
               end else if (word > MAX_WORDS) begin
                  state_d = S_ERR;
                  err_d   = 1'b1;
               end else begin
                  len_d   = word[ADDR_W:0];
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (word_done) begin
               wr_en_d   = 1'b1;
               wr_addr_d = BASE_ADDR + 32'(wl_q);
               wr_data_d = word;
               wl_d      = wl_q + WL_ONE;
               csum_d    = csum_q ^ word;
               if ((wl_q + WL_ONE) == len_q) begin
                  state_d = S_CSUM;
               end
            end
         end
         S_CSUM: begin
            if (word_done) begin
               if (word == csum_q) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  hold_d  = 1'b0;
               end else begin
                  state_d = S_ERR;
                  err_d   = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         bcnt_q    <= '0;
         asm_q     <= '0;
         csum_q    <= '0;
         len_q     <= '0;
         wl_q      <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         hold_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bcnt_q    <= bcnt_d;
         asm_q     <= asm_d;
         csum_q    <= csum_d;
         len_q     <= len_d;
         wl_q      <= wl_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         hold_q    <= hold_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign in_ready     = active;
   assign busy         = active;
   assign wr_en        = wr_en_q;
   assign wr_addr      = wr_addr_q;
   assign wr_data      = wr_data_q;
   assign cpu_hold     = hold_q;
   assign done         = done_q;
   assign err          = err_q;
   assign words_loaded = wl_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and randomized program loads compared
// against a word-list reference model of the expected writes and load outcome.
module tb_imem_loader;

   localparam int unsigned ADDR_W    = 16;
   localparam int unsigned MAX_WORDS = 65536;
   localparam int unsigned BASE_ADDR = 0;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic            in_valid = 1'b0;
   logic [7:0]      in_data = '0;
   logic            in_ready;
   logic            wr_en;
   logic [31:0]     wr_addr;
   logic [31:0]     wr_data;
   logic            cpu_hold;
   logic            busy;
   logic            done;
   logic            err;
   logic [ADDR_W:0] words_loaded;

   int n_assert = 0;
   int n_fail   = 0;
   int nbytes   = 0;

   logic [31:0] got_addr[$];
   logic [31:0] got_data[$];
   logic [31:0] prog[$];

   imem_loader #(
      .ADDR_W   (ADDR_W),
      .MAX_WORDS(MAX_WORDS),
      .BASE_ADDR(BASE_ADDR)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .cpu_hold    (cpu_hold),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Every write strobe must follow the completion of a whole data word: after the k-th
   // write, exactly 4 length bytes plus 4*k data bytes have been transferred.
   always @(negedge clk) begin
      if (!rst_n) begin
         nbytes = 0;
      end else begin
         if (wr_en) begin
            got_addr.push_back(wr_addr);
            got_data.push_back(wr_data);
            chk("wr_timing", 64'(nbytes), 64'(4 * (got_addr.size() + 1)));
         end
         if (start && !busy) nbytes = 0;
         if (in_valid && in_ready) nbytes++;
      end
   end

   // All stimulus changes happen 1 time unit after a rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int unsigned maxgap);
      int unsigned gap;
      gap = (maxgap == 0) ? 0 : $urandom_range(1, maxgap);
      in_valid = 1'b0;
      repeat (gap) tick();
      chk("in_ready_busy", 64'(in_ready), 64'(1));
      in_valid = 1'b1;
      in_data  = b;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int unsigned maxgap);
      for (int k = 0; k < 4; k++) send_byte(8'(w >> (8 * k)), maxgap);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Loads prog[] with declared length n and trailing checksum csum, then compares the
   // observed writes and status with what the load rules predict.
   task automatic run_load(input string tag, input logic [31:0] n, input logic [31:0] csum,
                           input int unsigned maxgap, input bit start_mid);
      logic [31:0] exp_x;
      bit          good;
      got_addr.delete();
      got_data.delete();
      pulse_start();
      chk({tag, ":hold_after_start"}, {cpu_hold, busy, done, err}, 4'b1100);
      chk({tag, ":wl_cleared"}, 64'(words_loaded), 64'(0));
      send_word(n, maxgap);
      if (n > MAX_WORDS) begin
         chk({tag, ":oversize_err"}, {err, done, in_ready, busy, cpu_hold}, 5'b10001);
         in_valid = 1'b1;
         in_data  = 8'hAA;
         tick();
         in_valid = 1'b0;
         chk({tag, ":oversize_stays"}, {err, in_ready, 17'(words_loaded)}, {1'b1, 1'b0, 17'd0});
         chk({tag, ":oversize_nowr"}, 64'(got_addr.size()), 64'(0));
         return;
      end
      exp_x = '0;
      for (int i = 0; i < int'(n); i++) begin
         if (start_mid && i == 1) start = 1'b1;
         send_word(prog[i], maxgap);
         start = 1'b0;
         exp_x ^= prog[i];
      end
      send_word(csum, maxgap);
      good = (csum == exp_x);
      repeat (2) tick();
      chk({tag, ":done"}, 64'(done), 64'(good));
      chk({tag, ":err"}, 64'(err), 64'(!good));
      chk({tag, ":cpu_hold"}, 64'(cpu_hold), 64'(!good));
      chk({tag, ":idle_ready"}, {in_ready, busy}, 2'b00);
      chk({tag, ":words_loaded"}, 64'(words_loaded), 64'(n));
      chk({tag, ":nwrites"}, 64'(got_addr.size()), 64'(n));
      for (int i = 0; i < got_addr.size() && i < int'(n); i++) begin
         chk({tag, ":wr_addr"}, 64'(got_addr[i]), 64'(BASE_ADDR + i));
         chk({tag, ":wr_data"}, 64'(got_data[i]), 64'(prog[i]));
      end
   endtask

   initial begin
      logic [31:0] x;
      int unsigned nw;

      #2;
      chk("reset_outputs", {in_ready, wr_en, cpu_hold, busy, done, err, 17'(words_loaded)}, '0);
      chk("reset_bus", {wr_addr, wr_data}, '0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      chk("idle_ready", {in_ready, busy}, 2'b00);

      prog = '{32'h0000_0013, 32'h0010_0093};
      run_load("basic", 32'd2, 32'h0010_0080, 0, 1'b0);
      run_load("badcsum", 32'd2, 32'h0110_0080, 0, 1'b0);
      run_load("restart_good", 32'd2, 32'h0010_0080, 0, 1'b0);

      prog.delete();
      run_load("empty", 32'd0, 32'd0, 0, 1'b0);
      run_load("oversize", MAX_WORDS + 1, 32'd0, 0, 1'b0);

      prog = '{32'h0000_0013, 32'h0010_0093};
      run_load("gaps", 32'd2, 32'h0010_0080, 5, 1'b0);

      // Reset in the middle of the second data word.
      prog = '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666};
      got_addr.delete();
      got_data.delete();
      pulse_start();
      send_word(32'd3, 0);
      send_word(prog[0], 0);
      send_byte(8'h44, 0);
      send_byte(8'h44, 0);
      rst_n = 1'b0;
      #1;
      chk("midreset_outputs", {in_ready, wr_en, cpu_hold, busy, done, err, 17'(words_loaded)}, '0);
      got_addr.delete();
      got_data.delete();
      repeat (6) tick();
      rst_n = 1'b1;
      repeat (6) tick();
      chk("midreset_nowr", 64'(got_addr.size()), 64'(0));
      prog = '{32'h0000_0013, 32'h0010_0093};
      run_load("after_reset", 32'd2, 32'h0010_0080, 0, 1'b0);

      prog = '{32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h1234_5678};
      run_load("start_in_data", 32'd3, 32'hDEAD_BEEF ^ 32'h0BAD_F00D ^ 32'h1234_5678, 0, 1'b1);

      for (int t = 0; t < 6; t++) begin
         nw = $urandom_range(1, 7);
         prog.delete();
         x = '0;
         for (int i = 0; i < int'(nw); i++) begin
            prog.push_back($urandom);
            x ^= prog[i];
         end
         if ($urandom_range(0, 1) == 1) x ^= (32'd1 << $urandom_range(0, 31));
         run_load("random", 32'(nw), x, $urandom_range(0, 1) * 5, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory: receives a program as a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word into the instruction memory write port at consecutive word addresses.
- Verifies a trailing XOR checksum.
- Holds the CPU stalled for the whole load; sits between the host/UART byte source and the instruction memory write port.

Parameters:
- ADDR_W, 16, width of the word index; memory depth is 2^ADDR_W words.
- MAX_WORDS, 65536, largest accepted program length in words; must be ≤ 2^ADDR_W.
- BASE_ADDR, 0, word address of the first written instruction.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- in_valid  input  1  byte source has a byte on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle; a transfer occurs when in_valid & in_ready.
- wr_en  output  1  one-cycle instruction memory write strobe.
- wr_addr  output  32  word address for the write (same word indexing as the PC); upper bits above ADDR_W are zero.
- wr_data  output  32  instruction word to write.
- cpu_hold  output  1  stall request to the CPU/PC.
- busy  output  1  high in LEN, DATA and CSUM.
- done  output  1  load completed with good checksum; sticky.
- err  output  1  load failed (length out of range or checksum mismatch); sticky.
- words_loaded  output  ADDR_W+1  count of words written in the current/last load.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, all outputs 0, byte counter, word counter, length and checksum cleared. Any partial word is discarded; no wr_en is issued during or after reset.
- States: IDLE, LEN, DATA, CSUM, DONE, ERR.
- Byte assembly (LEN, DATA, CSUM):
  - 2-bit byte counter; byte k of a word goes to bits [8k+7:8k]; the first received byte is the LSB.
  - A word completes on the transfer that sets the counter to 3→0.
  - Cycles with in_valid low stall assembly with no state change.
- in_ready = 1 in LEN, DATA and CSUM; 0 in IDLE, DONE and ERR.
- IDLE/DONE/ERR + start:
  - go to LEN; clear done, err, words_loaded, checksum and byte counter.
  - cpu_hold = 1 from the cycle after start.
- LEN: the completed word is the program length N.
  - N = 0 → CSUM.
  - N > MAX_WORDS → ERR.
  - Otherwise latch N → DATA.
- DATA, on each completed word:
  - Next cycle: wr_en = 1 for exactly one cycle, wr_addr = BASE_ADDR + words_loaded, wr_data = the word; words_loaded increments in that same cycle.
  - checksum ^= word.
  - After the Nth word completes → CSUM. The Nth write strobe occurs in the first CSUM cycle.
- CSUM: the completed word is compared with the XOR of all data words; the length word is excluded, and the XOR of zero words is 0.
  - Equal → DONE: done = 1, cpu_hold = 0.
  - Otherwise → ERR: err = 1, cpu_hold stays 1.
- Maximum throughput is one byte per cycle. Write strobes are therefore at least 4 cycles apart, and no write buffering is needed.
- start while busy is ignored; the load continues undisturbed.
- Address wrap: not possible, since N ≤ MAX_WORDS ≤ 2^ADDR_W. The final wr_addr is BASE_ADDR + N − 1, with no overflow past 32 bits.
- done and err are never high simultaneously.
- Re-entry: from DONE or ERR, a new start restarts cleanly. Previously written memory contents are not cleared.

Test Plan:
- Basic load:
  - Stimulus: start; bytes 02 00 00 00 | 13 00 00 00 | 93 00 10 00 | 80 00 10 00.
  - Required: wr_en twice, addr 0 data 0x00000013, then addr 1 data 0x00100093.
  - Required: done=1, err=0, cpu_hold=0, words_loaded=2.
- Bad checksum:
  - Stimulus: same stream with last byte 01.
  - Required: both writes occur; then err=1, done=0, cpu_hold=1.
- Empty and oversize lengths:
  - Stimulus: N=0 with checksum 0 → required: done=1 with no wr_en.
  - Stimulus: N=MAX_WORDS+1 → required: err=1 right after the 4th byte, in_ready=0 afterwards.
- Backpressure/gaps:
  - Stimulus: basic stream with in_valid low for 1–5 random cycles between bytes.
  - Required: identical writes and result; no wr_en while a word is partial.
- Reset mid-load:
  - Stimulus: assert rst_n low after 2 bytes of the second data word.
  - Required: outputs 0 immediately; no further wr_en; a subsequent start plus the basic stream succeeds.
- start during DATA:
  - Stimulus: pulse start while in DATA.
  - Required: ignored; words_loaded continues; final done=1.
